// File: rtl/pixelstream2vesa_if.sv
// rtl/pixelstream2vesa_if.sv - pixel stream in / VESA raster out bundle
interface pixelstream2vesa_if #(
  parameter int DATA_WIDTH = 24
);
  logic [DATA_WIDTH-1:0] pixel_data_in;
  logic                  pixel_valid_in;
  logic                  v_start_in;
  logic                  hsync;
  logic                  vsync;
  logic                  de;
  logic [DATA_WIDTH-1:0] pixel_data_out;

  modport master (
    output pixel_data_in, pixel_valid_in, v_start_in,
    input  hsync, vsync, de, pixel_data_out
  );

  modport slave (
    input  pixel_data_in, pixel_valid_in, v_start_in,
    output hsync, vsync, de, pixel_data_out
  );
endinterface

// File: rtl/pixelstream2vesa.sv
// rtl/pixelstream2vesa.sv - pixel FIFO feeding a free-running VESA raster generator
// The FIFO arms on the first frame-start pixel; the raster starts once START_LEVEL pixels are buffered.
module pixelstream2vesa #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_AW     = 11,
  parameter int START_LEVEL = 16,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int H_ADDR      = 1280,
  parameter int H_FP        = 110,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int V_ADDR      = 720,
  parameter int V_FP        = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pixelstream2vesa_if.slave    vid,
  input  logic                 clr_flags,
  output logic                 running,
  output logic [FIFO_AW:0]     fifo_level,
  output logic                 underflow,
  output logic                 overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [11:0] H_SYNC_C   = 12'(H_SYNC);
  localparam logic [11:0] HA_START_C = 12'(H_SYNC + H_BP);
  localparam logic [11:0] HA_END_C   = 12'(H_SYNC + H_BP + H_ADDR);
  localparam logic [11:0] H_LAST_C   = 12'(H_SYNC + H_BP + H_ADDR + H_FP - 1);
  localparam logic [11:0] V_SYNC_C   = 12'(V_SYNC);
  localparam logic [11:0] VA_START_C = 12'(V_SYNC + V_BP);
  localparam logic [11:0] VA_END_C   = 12'(V_SYNC + V_BP + V_ADDR);
  localparam logic [11:0] V_LAST_C   = 12'(V_SYNC + V_BP + V_ADDR + V_FP - 1);

  localparam logic [FIFO_AW:0] LEVEL_FULL_C  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] LEVEL_START_C = (FIFO_AW + 1)'(START_LEVEL);

  typedef enum logic {ST_WAIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [FIFO_AW:0]      wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]      rd_ptr_q, rd_ptr_d;
  logic [11:0]           hcnt_q, hcnt_d;
  logic [11:0]           vcnt_q, vcnt_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;
  logic                  de_q, de_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic                  running_q, running_d;
  logic                  underflow_q, underflow_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [FIFO_AW:0] level;
  logic             empty, full, in_run;
  logic             hsync_raw, vsync_raw, de_raw;
  logic             push_req, push, pop;

  always_comb begin
    level     = wr_ptr_q - rd_ptr_q;
    empty     = (level == '0);
    full      = (level == LEVEL_FULL_C);
    in_run    = (state_q == ST_RUN);

    hsync_raw = in_run && (hcnt_q < H_SYNC_C);
    vsync_raw = in_run && (vcnt_q < V_SYNC_C);
    de_raw    = in_run && (hcnt_q >= HA_START_C) && (hcnt_q < HA_END_C)
                       && (vcnt_q >= VA_START_C) && (vcnt_q < VA_END_C);

    pop       = de_raw && !empty;
    push_req  = vid.pixel_valid_in && (armed_q || vid.v_start_in);
    // A pop in the same cycle frees the slot, so a push at full still proceeds.
    push      = push_req && (!full || pop);

    armed_d   = armed_q || (vid.pixel_valid_in && vid.v_start_in);
    wr_ptr_d  = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
    rd_ptr_d  = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};

    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    if (state_q == ST_WAIT) begin
      hcnt_d = '0;
      vcnt_d = '0;
      if (level >= LEVEL_START_C) begin
        // Land one clock before the first active pixel of the first active line.
        state_d = ST_RUN;
        hcnt_d  = HA_START_C - 12'd1;
        vcnt_d  = VA_START_C;
      end
    end else begin
      if (hcnt_q == H_LAST_C) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST_C) ? 12'd0 : vcnt_q + 12'd1;
      end else begin
        hcnt_d = hcnt_q + 12'd1;
      end
    end

    running_d   = (state_d == ST_RUN);
    hsync_d     = hsync_raw;
    vsync_d     = vsync_raw;
    de_d        = de_raw;
    pix_d       = pop ? mem[rd_ptr_q[FIFO_AW-1:0]] : '0;
    underflow_d = (de_raw && empty) || (underflow_q && !clr_flags);
    overflow_d  = (push_req && full && !pop) || (overflow_q && !clr_flags);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= vid.pixel_data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT;
      armed_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      pix_q       <= '0;
      running_q   <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      pix_q       <= pix_d;
      running_q   <= running_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign vid.hsync          = hsync_q;
  assign vid.vsync          = vsync_q;
  assign vid.de             = de_q;
  assign vid.pixel_data_out = pix_q;
  assign running            = running_q;
  assign fifo_level         = level;
  assign underflow          = underflow_q;
  assign overflow           = overflow_q;

endmodule
